// File: rtl/apb_mux_pkg.sv
// Shared encodings for the multi-channel APB completer: one-hot FSM states,
// last-error status codes and a width helper.
package apb_mux_pkg;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] S_IDLE   = 4'b0001;
  localparam logic [ST_W-1:0] S_ACCESS = 4'b0010;
  localparam logic [ST_W-1:0] S_DONE   = 4'b0100;
  localparam logic [ST_W-1:0] S_ERROR  = 4'b1000;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SLAVE   = 2'd3;

  // clog2 that never returns 0, so derived vectors are always at least 1 bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/apb_mux_if.sv
// Upstream APB completer bus. Signal names are from the completer's point of view.
interface apb_mux_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          apb_psel_in;
  logic          apb_penable_in;
  logic          apb_write_in;
  logic [AW-1:0] apb_addr_in;
  logic [DW-1:0] apb_wdata_in;
  logic [SW-1:0] apb_strb_in;
  logic [2:0]    apb_prot_in;
  logic [DW-1:0] apb_rdata_out;
  logic          apb_ready_out;
  logic          apb_slverr_out;

  modport slave (
    input  apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in,
           apb_wdata_in, apb_strb_in, apb_prot_in,
    output apb_rdata_out, apb_ready_out, apb_slverr_out
  );

  modport master (
    output apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in,
           apb_wdata_in, apb_strb_in, apb_prot_in,
    input  apb_rdata_out, apb_ready_out, apb_slverr_out
  );

endinterface

// File: rtl/apb_mux_timeout_cnt.sv
// Wait-state counter for the access phase; expire_o flags the count reaching
// TIMEOUT_CYCLES. Collapses to a constant when the timeout is disabled.
module apb_mux_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic apb_clk_in,
  input  logic apb_rstn_in,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused;
    assign unused   = apb_clk_in ^ apb_rstn_in ^ clr_i ^ en_i;
    assign expire_o = 1'b0;
  end else begin : g_on
    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                 cnt_d = '0;
      else if (en_i && !expire_o) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) cnt_q <= '0;
      else              cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_slave_mux_if.sv
// APB completer fanning out to NUM_CH downstream channels by address window,
// with wait-state timeout, protocol checking and a last-error status code.
module apb_slave_mux_if
  import apb_mux_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_CH         = 4,
  parameter int CH_SEL_LSB     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             apb_clk_in,
  input  logic                             apb_rstn_in,
  apb_mux_if.slave                         apb_if,
  output logic [NUM_CH-1:0]                other_sel_out,
  output logic [APB_ADDR_WIDTH-1:0]        other_addr_out,
  output logic [APB_DATA_WIDTH-1:0]        other_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0]      other_strb_out,
  output logic [2:0]                       other_prot_out,
  output logic                             other_write_out,
  input  logic [NUM_CH-1:0]                other_ready_in,
  input  logic [NUM_CH-1:0]                other_error_in,
  input  logic [NUM_CH*APB_DATA_WIDTH-1:0] other_rdata_in,
  output logic [1:0]                       last_err_out
);

  localparam int CH_BITS    = clog2_min1(NUM_CH);
  localparam int STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int TO_W       = clog2_min1(TIMEOUT_CYCLES + 1);

  logic [ST_W-1:0]           state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [2:0]                prot_q, prot_d;
  logic                      write_q, write_d;
  logic [CH_BITS-1:0]        ch_q, ch_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                last_err_q, last_err_d;
  logic                      cnt_en, to_expire;

  // Whole field above CH_SEL_LSB must index a real channel; stray upper bits miss
  logic [APB_ADDR_WIDTH-1:0] idx;
  logic                      hit;
  assign idx = apb_if.apb_addr_in >> CH_SEL_LSB;
  assign hit = (idx < APB_ADDR_WIDTH'(NUM_CH));

  logic [NUM_CH-1:0][APB_DATA_WIDTH-1:0] rdata_arr;
  logic                                  ch_rdy, ch_err;
  logic [APB_DATA_WIDTH-1:0]             ch_rdata;
  assign rdata_arr = other_rdata_in;
  assign ch_rdy    = other_ready_in[ch_q];
  assign ch_err    = other_error_in[ch_q];
  assign ch_rdata  = rdata_arr[ch_q];

  // Master must hold the whole request stable through the access phase
  logic viol;
  assign viol = !apb_if.apb_penable_in
             || (apb_if.apb_addr_in  != addr_q)
             || (apb_if.apb_write_in != write_q)
             || (apb_if.apb_strb_in  != strb_q)
             || (apb_if.apb_prot_in  != prot_q)
             || (write_q && (apb_if.apb_wdata_in != wdata_q));

  apb_mux_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_to (
    .apb_clk_in (apb_clk_in),
    .apb_rstn_in(apb_rstn_in),
    .clr_i      (state_q != S_ACCESS),
    .en_i       (cnt_en),
    .expire_o   (to_expire)
  );

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prot_q     <= '0;
      write_q    <= 1'b0;
      ch_q       <= '0;
      rdata_q    <= '0;
      last_err_q <= ERR_OK;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prot_q     <= prot_d;
      write_q    <= write_d;
      ch_q       <= ch_d;
      rdata_q    <= rdata_d;
      last_err_q <= last_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prot_d     = prot_q;
    write_d    = write_q;
    ch_d       = ch_q;
    rdata_d    = rdata_q;
    last_err_d = last_err_q;
    cnt_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (apb_if.apb_psel_in && !apb_if.apb_penable_in) begin
          addr_d  = apb_if.apb_addr_in;
          wdata_d = apb_if.apb_wdata_in;
          strb_d  = apb_if.apb_strb_in;
          prot_d  = apb_if.apb_prot_in;
          write_d = apb_if.apb_write_in;
          ch_d    = idx[CH_BITS-1:0];
          rdata_d = '0;
          if (hit) begin
            state_d = S_ACCESS;
          end else begin
            state_d    = S_ERROR;
            last_err_d = ERR_DECODE;
          end
        end
      end
      S_ACCESS: begin
        if (!apb_if.apb_psel_in) begin
          state_d = S_IDLE;
        end else if (viol || (ch_rdy && ch_err)) begin
          state_d    = S_ERROR;
          last_err_d = ERR_SLAVE;
        end else if (ch_rdy) begin
          state_d    = S_DONE;
          last_err_d = ERR_OK;
          rdata_d    = write_q ? '0 : ch_rdata;
        end else if (to_expire) begin
          state_d    = S_ERROR;
          last_err_d = ERR_TIMEOUT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Select and completion strobes decode straight from state so reset drops them at once
  always_comb begin
    other_sel_out         = '0;
    apb_if.apb_ready_out  = 1'b0;
    apb_if.apb_slverr_out = 1'b0;
    apb_if.apb_rdata_out  = '0;
    case (state_q)
      S_ACCESS: other_sel_out = NUM_CH'(1) << ch_q;
      S_DONE: begin
        apb_if.apb_ready_out = 1'b1;
        apb_if.apb_rdata_out = rdata_q;
      end
      S_ERROR: begin
        apb_if.apb_ready_out  = 1'b1;
        apb_if.apb_slverr_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign other_addr_out  = addr_q;
  assign other_wdata_out = wdata_q;
  assign other_strb_out  = strb_q;
  assign other_prot_out  = prot_q;
  assign other_write_out = write_q;
  assign last_err_out    = last_err_q;

endmodule

// File: tb/tb_apb_slave_mux_if.sv
// Self-checking bench: table vectors, randomized transfers against a latency/result
// model, and hand sequences for protocol violations, abort and reset.
module tb_apb_slave_mux_if;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  apb_mux_if #(.AW(AW), .DW(DW)) bus ();

  logic [NCH-1:0]          sel, rdy, err;
  logic [AW-1:0]           oaddr;
  logic [DW-1:0]           owdata;
  logic [DW/8-1:0]         ostrb;
  logic [2:0]              oprot;
  logic                    owrite;
  logic [NCH-1:0][DW-1:0]  chan_data;
  logic [1:0]              lerr;

  apb_slave_mux_if #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_CH(NCH),
    .CH_SEL_LSB(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .apb_clk_in     (clk),
    .apb_rstn_in    (rstn),
    .apb_if         (bus.slave),
    .other_sel_out  (sel),
    .other_addr_out (oaddr),
    .other_wdata_out(owdata),
    .other_strb_out (ostrb),
    .other_prot_out (oprot),
    .other_write_out(owrite),
    .other_ready_in (rdy),
    .other_error_in (err),
    .other_rdata_in (chan_data),
    .last_err_out   (lerr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    int          wait_n;
    logic        serr;
    int          exp_edges;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: edges after the setup sample until pready is visible, and the status code
  function automatic void model(input logic [31:0] addr, input int wait_n, input logic serr,
                                output int edges, output logic [1:0] code);
    if ((addr >> 12) >= NCH) begin
      edges = 0; code = 2'd1;
    end else if (wait_n > TO) begin
      edges = TO + 1; code = 2'd2;
    end else begin
      edges = wait_n + 1; code = serr ? 2'd3 : 2'd0;
    end
  endfunction

  task automatic bus_idle();
    bus.apb_psel_in    = 1'b0;
    bus.apb_penable_in = 1'b0;
    rdy = '0;
    err = '0;
  endtask

  task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot);
    bus.apb_psel_in    = 1'b1;
    bus.apb_penable_in = 1'b0;
    bus.apb_write_in   = wr;
    bus.apb_addr_in    = addr;
    bus.apb_wdata_in   = wd;
    bus.apb_strb_in    = strb;
    bus.apb_prot_in    = prot;
  endtask

  // Target channel raises ready after wait_n low samples; other channels carry noise
  task automatic run_xfer(input string nm, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input int wait_n, input logic serr,
                          input int exp_edges, input logic [1:0] exp_code);
    logic        miss;
    logic [1:0]  ch;
    logic [3:0]  strb, rn, en;
    logic [2:0]  prot;
    logic [31:0] exp_rd;
    int          edges;
    miss   = (exp_code == 2'd1);
    ch     = addr[13:12];
    strb   = 4'($urandom);
    prot   = 3'($urandom);
    exp_rd = (exp_code == 2'd0 && !wr) ? chan_data[ch] : 32'h0;
    setup(addr, wr, wd, strb, prot);
    rdy = 4'($urandom);
    err = 4'($urandom);
    tick();
    chk({nm, " sel"}, 64'(sel), miss ? 64'h0 : 64'(1 << ch));
    chk({nm, " addr"}, 64'(oaddr), 64'(addr));
    chk({nm, " wdata"}, 64'(owdata), 64'(wd));
    chk({nm, " write/strb/prot"}, 64'({owrite, ostrb, oprot}), 64'({wr, strb, prot}));
    bus.apb_penable_in = 1'b1;
    edges = 0;
    while (bus.apb_ready_out !== 1'b1 && edges < 40) begin
      rn = 4'($urandom);
      en = 4'($urandom);
      if (!miss) begin
        rn[ch] = (edges >= wait_n);
        if (rn[ch]) en[ch] = serr;
      end
      rdy = rn;
      err = en;
      tick();
      edges++;
    end
    chk({nm, " latency"}, 64'(edges), 64'(exp_edges));
    chk({nm, " slverr"}, 64'(bus.apb_slverr_out), 64'(exp_code != 2'd0));
    chk({nm, " last_err"}, 64'(lerr), 64'(exp_code));
    chk({nm, " rdata"}, 64'(bus.apb_rdata_out), 64'(exp_rd));
    chk({nm, " sel cleared"}, 64'(sel), 64'h0);
    tick();
    chk({nm, " pready pulse"}, 64'(bus.apb_ready_out), 64'h0);
    bus_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic        wr, e;
    int          w, xe;
    logic [1:0]  xc;

    tbl[0] = '{32'h0000_2010, 1'b1, 32'hA5A5_5A5A, 0,   1'b0, 1,  2'd0};
    tbl[1] = '{32'h0000_1004, 1'b0, 32'h0,         4,   1'b0, 5,  2'd0};
    tbl[2] = '{32'h0000_5000, 1'b0, 32'h0,         0,   1'b0, 0,  2'd1};
    tbl[3] = '{32'h0000_0000, 1'b0, 32'h0,         100, 1'b0, 17, 2'd2};
    tbl[4] = '{32'h0000_0008, 1'b1, 32'h1234_5678, 0,   1'b0, 1,  2'd0};
    tbl[5] = '{32'h0000_3000, 1'b0, 32'h0,         2,   1'b1, 3,  2'd3};
    tbl[6] = '{32'h0000_0010, 1'b0, 32'h0,         16,  1'b0, 17, 2'd0};
    tbl[7] = '{32'h0000_1000, 1'b1, 32'hCAFE_F00D, 17,  1'b0, 17, 2'd2};
    tbl[8] = '{32'h0000_3FFC, 1'b0, 32'h0,         0,   1'b0, 1,  2'd0};
    tbl[9] = '{32'h0001_0000, 1'b1, 32'h0BAD_0BAD, 0,   1'b0, 0,  2'd1};

    for (int k = 0; k < NCH; k++) chan_data[k] = $urandom;
    chan_data[1] = 32'hDEAD_BEEF;
    bus_idle();
    bus.apb_write_in = 1'b0;
    bus.apb_addr_in  = '0;
    bus.apb_wdata_in = '0;
    bus.apb_strb_in  = '0;
    bus.apb_prot_in  = '0;

    repeat (3) tick();
    chk("reset sel", 64'(sel), 64'h0);
    chk("reset pready/slverr", 64'({bus.apb_ready_out, bus.apb_slverr_out}), 64'h0);
    chk("reset last_err", 64'(lerr), 64'h0);
    chk("reset addr", 64'(oaddr), 64'h0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      run_xfer($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wd,
               tbl[i].wait_n, tbl[i].serr, tbl[i].exp_edges, tbl[i].exp_code);

    // Address changes mid-access
    setup(32'h0000_2000, 1'b0, 32'h0, 4'hF, 3'd0);
    tick();
    bus.apb_penable_in = 1'b1;
    tick();
    bus.apb_addr_in = 32'h0000_2004;
    tick();
    chk("addr change pready/slverr", 64'({bus.apb_ready_out, bus.apb_slverr_out}), 64'h3);
    chk("addr change last_err", 64'(lerr), 64'h3);
    chk("addr change sel", 64'(sel), 64'h0);
    tick();
    bus_idle();

    // psel drop mid-access: abort, no completion, status untouched
    run_xfer("pre-abort", 32'h0000_0100, 1'b1, 32'h5555_AAAA, 1, 1'b0, 2, 2'd0);
    setup(32'h0000_1000, 1'b0, 32'h0, 4'hF, 3'd0);
    tick();
    bus.apb_penable_in = 1'b1;
    tick();
    bus_idle();
    tick();
    chk("abort pready", 64'(bus.apb_ready_out), 64'h0);
    chk("abort sel", 64'(sel), 64'h0);
    chk("abort last_err", 64'(lerr), 64'h0);
    tick();
    chk("abort pready later", 64'(bus.apb_ready_out), 64'h0);
    run_xfer("post-abort", 32'h0000_1040, 1'b0, 32'h0, 0, 1'b0, 1, 2'd0);

    // psel+penable in IDLE is not a setup phase
    setup(32'h0000_1000, 1'b0, 32'h0, 4'hF, 3'd0);
    bus.apb_penable_in = 1'b1;
    rdy = '1;
    tick();
    tick();
    chk("idle penable sel", 64'(sel), 64'h0);
    chk("idle penable pready", 64'(bus.apb_ready_out), 64'h0);
    bus_idle();
    tick();

    // Write data changes mid-access
    setup(32'h0000_3000, 1'b1, 32'h1111_2222, 4'hF, 3'd1);
    tick();
    bus.apb_penable_in = 1'b1;
    bus.apb_wdata_in   = 32'h1111_2223;
    tick();
    chk("wdata change slverr", 64'({bus.apb_ready_out, bus.apb_slverr_out}), 64'h3);
    chk("wdata change last_err", 64'(lerr), 64'h3);
    tick();
    bus_idle();

    // Reset while ch1 is waiting
    setup(32'h0000_1000, 1'b0, 32'h0, 4'hF, 3'd2);
    tick();
    bus.apb_penable_in = 1'b1;
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst sel", 64'(sel), 64'h0);
    chk("rst apb outs", 64'({bus.apb_ready_out, bus.apb_slverr_out, bus.apb_rdata_out}), 64'h0);
    chk("rst last_err", 64'(lerr), 64'h0);
    chk("rst latched", 64'({oaddr, ostrb, oprot, owrite}), 64'h0);
    chk("rst wdata", 64'(owdata), 64'h0);
    bus_idle();
    tick();
    rstn = 1'b1;
    tick();
    run_xfer("post-reset", 32'h0000_1008, 1'b0, 32'h0, 0, 1'b0, 1, 2'd0);

    for (int i = 0; i < 40; i++) begin
      a  = (32'($urandom_range(0, 6)) << 12) | 32'($urandom_range(0, 4095));
      wr = 1'($urandom);
      wd = $urandom;
      w  = $urandom_range(0, 20);
      e  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NCH; k++) chan_data[k] = $urandom;
      model(a, w, e, xe, xc);
      run_xfer($sformatf("rand%0d", i), a, wr, wd, w, e, xe, xc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
